tcc32_timer: RTL and testbench

32-bit timer/counter/capture peripheral core, driven by a register-bank wrapper that supplies all configuration as static inputs.
- Counts prescaled system clock ticks, or synchronized external edges on ctr_in, up or down against a programmable period.
- Provides timeout and compare-match pulses.
- Capture unit measures the interval between selected ctr_in edges.

---
 rtl/tcc32_timer.sv | 182 ++++++++++++++++++
 tb/tb_tcc32_timer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tcc32_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tcc32_timer : 32-bit timer/counter with compare match and edge capture.    |
// | Optional PWM output enabled by defining TCC32_PWM_EN.   Revision 1.0       |
// +----------------------------------------------------------------------------+
module tcc32_timer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        tmr_en,
  input  logic [3:0]  clk_src,
  input  logic        up,
  input  logic        one_shot,
  input  logic [31:0] period,
  input  logic [31:0] ctr_match,
  input  logic        ctr_in,
  input  logic        cp_en,
  input  logic [1:0]  cp_event,
`ifdef TCC32_PWM_EN
  input  logic        pwm_en,
  input  logic [31:0] pwm_cmp,
  output logic        pwm_out,
`endif
  output logic [31:0] tmr,
  output logic [31:0] cp_count,
  output logic        to_flag,
  output logic        match_flag,
  output logic        cp_flag
);

  localparam int c_SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [7:0]      r_presc;
  logic [c_SS-1:0] r_sync;
  logic            r_sync_d;
  logic [31:0]     r_tmr;
  logic            r_done;
  logic            r_to;
  logic            r_match;
  logic [31:0]     r_cp_count;
  logic [31:0]     r_ictr;
  logic            r_armed;
  logic            r_cpf;

  logic [7:0]      w_mask;
  logic            w_tick;
  logic            w_rise;
  logic            w_fall;
  logic            w_cp_sel;
  logic            w_term;
  logic [31:0]     w_reload;
  logic [31:0]     w_tmr_nxt;
  logic            w_cnt;

  // Free-running prescaler; cleared whenever the block is disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= 8'd0;
    end else if (en) begin
      r_presc <= r_presc + 8'd1;
    end else begin
      r_presc <= 8'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync   <= '0;
      r_sync_d <= 1'b0;
    end else begin
      r_sync   <= {r_sync[c_SS-2:0], ctr_in};
      r_sync_d <= r_sync[c_SS-1];
    end
  end

  assign w_rise   = r_sync[c_SS-1] & ~r_sync_d;
  assign w_fall   = ~r_sync[c_SS-1] & r_sync_d;
  assign w_cp_sel = (cp_event[0] & w_rise) | (cp_event[1] & w_fall);

  // clk/2^n ticks when the low n prescaler bits are all ones.
  always_comb begin
    w_mask = 8'h00;
    w_tick = 1'b0;
    if (clk_src <= 4'd8) begin
      w_mask = 8'((9'd1 << clk_src) - 9'd1);
      w_tick = en & ((r_presc & w_mask) == w_mask);
    end else if (clk_src == 4'd9) begin
      w_tick = en & w_rise;
    end
  end

  always_comb begin
    w_term   = up ? (r_tmr == period) : (r_tmr == 32'd0);
    w_reload = up ? 32'd0 : period;
    if (w_term) begin
      w_tmr_nxt = w_reload;
    end else if (up) begin
      w_tmr_nxt = r_tmr + 32'd1;
    end else begin
      w_tmr_nxt = r_tmr - 32'd1;
    end
  end

  assign w_cnt = w_tick & tmr_en & ~r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmr   <= 32'd0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      r_match <= 1'b0;
    end else begin
      r_to    <= 1'b0;
      r_match <= 1'b0;
      if (en) begin
        if (!tmr_en) begin
          r_tmr  <= w_reload;
          r_done <= 1'b0;
        end else if (w_cnt) begin
          r_tmr   <= w_tmr_nxt;
          r_to    <= w_term;
          r_match <= (w_tmr_nxt == ctr_match);
          if (w_term && one_shot) begin
            r_done <= 1'b1;
          end
        end
      end
    end
  end

  // An edge outranks a tick in the same cycle: the interval restarts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cp_count <= 32'd0;
      r_ictr     <= 32'd0;
      r_armed    <= 1'b0;
      r_cpf      <= 1'b0;
    end else begin
      r_cpf <= 1'b0;
      if (!cp_en) begin
        r_ictr  <= 32'd0;
        r_armed <= 1'b0;
      end else if (en) begin
        if (w_cp_sel) begin
          if (r_armed) begin
            r_cp_count <= r_ictr;
            r_cpf      <= 1'b1;
          end
          r_ictr  <= 32'd0;
          r_armed <= 1'b1;
        end else if (w_tick && r_armed && (r_ictr != 32'hFFFF_FFFF)) begin
          r_ictr <= r_ictr + 32'd1;
        end
      end
    end
  end

`ifdef TCC32_PWM_EN
  logic r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= pwm_en & tmr_en & en & (r_tmr < pwm_cmp);
    end
  end

  assign pwm_out = r_pwm;
`endif

  assign tmr        = r_tmr;
  assign cp_count   = r_cp_count;
  assign to_flag    = r_to;
  assign match_flag = r_match;
  assign cp_flag    = r_cpf;

endmodule
`default_nettype wire

// File: tb/tb_tcc32_timer.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_tcc32_timer : directed plus randomized bench against a behavioural model.|
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_tcc32_timer;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        tmr_en = 1'b0;
  logic [3:0]  clk_src = 4'd0;
  logic        up = 1'b0;
  logic        one_shot = 1'b0;
  logic [31:0] period = 32'd0;
  logic [31:0] ctr_match = 32'd0;
  logic        ctr_in = 1'b0;
  logic        cp_en = 1'b0;
  logic [1:0]  cp_event = 2'd0;
  logic [31:0] tmr;
  logic [31:0] cp_count;
  logic        to_flag;
  logic        match_flag;
  logic        cp_flag;

  int total = 0;
  int bad = 0;
  int cycn = 0;
  int to_seen = 0;
  int to_last = 0;
  int to_prev = 0;
  int match_seen = 0;
  int cpf_seen = 0;

  logic [31:0] m_tmr, m_cpc, m_ictr;
  logic        m_done, m_to, m_match, m_cpf, m_armed;
  int          m_pc;
  logic        hist[$];

  tcc32_timer #(.SYNC_STAGES(S)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .tmr_en(tmr_en), .clk_src(clk_src),
    .up(up), .one_shot(one_shot), .period(period), .ctr_match(ctr_match),
    .ctr_in(ctr_in), .cp_en(cp_en), .cp_event(cp_event), .tmr(tmr),
    .cp_count(cp_count), .to_flag(to_flag), .match_flag(match_flag),
    .cp_flag(cp_flag)
  );

  always #50 clk = ~clk;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_tmr = 0; m_cpc = 0; m_ictr = 0;
    m_done = 0; m_to = 0; m_match = 0; m_cpf = 0; m_armed = 0;
    m_pc = 0;
    hist.delete();
    for (int i = 0; i <= S; i++) hist.push_back(1'b0);
  endtask

  // ctr_in seen by the edge detector lags the pin by S clock edges.
  task automatic m_step();
    logic rise, fall, tick, sel;
    logic [31:0] nxt;
    int n;
    rise = hist[hist.size()-S] & ~hist[hist.size()-S-1];
    fall = ~hist[hist.size()-S] & hist[hist.size()-S-1];
    hist.push_back(ctr_in);
    hist.delete(0);
    tick = 1'b0;
    if (en) begin
      if (clk_src <= 4'd8) begin
        n = 1 << clk_src;
        tick = ((m_pc % n) == n - 1);
      end else if (clk_src == 4'd9) begin
        tick = rise;
      end
    end
    m_pc = en ? (m_pc + 1) % 256 : 0;
    m_to = 1'b0;
    m_match = 1'b0;
    if (en) begin
      if (!tmr_en) begin
        m_tmr = up ? 32'd0 : period;
        m_done = 1'b0;
      end else if (tick && !m_done) begin
        if (up) begin
          if (m_tmr == period) begin nxt = 32'd0; m_to = 1'b1; end
          else nxt = m_tmr + 32'd1;
        end else begin
          if (m_tmr == 32'd0) begin nxt = period; m_to = 1'b1; end
          else nxt = m_tmr - 32'd1;
        end
        m_tmr = nxt;
        m_match = (nxt == ctr_match);
        if (m_to && one_shot) m_done = 1'b1;
      end
    end
    sel = (cp_event[0] & rise) | (cp_event[1] & fall);
    m_cpf = 1'b0;
    if (!cp_en) begin
      m_armed = 1'b0;
      m_ictr = 32'd0;
    end else if (en) begin
      if (sel) begin
        if (m_armed) begin m_cpc = m_ictr; m_cpf = 1'b1; end
        m_ictr = 32'd0;
        m_armed = 1'b1;
      end else if (tick && m_armed && m_ictr != 32'hFFFF_FFFF) begin
        m_ictr = m_ictr + 32'd1;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    m_step();
    @(negedge clk);
    cycn++;
    chk32("tmr", tmr, m_tmr);
    chk32("cp_count", cp_count, m_cpc);
    chk1("to_flag", to_flag, m_to);
    chk1("match_flag", match_flag, m_match);
    chk1("cp_flag", cp_flag, m_cpf);
    if (to_flag) begin to_seen++; to_prev = to_last; to_last = cycn; end
    if (match_flag) match_seen++;
    if (cp_flag) cpf_seen++;
  endtask

  // Square wave on ctr_in with the given half period, quantised to the clock.
  task automatic run_sq(input int ncyc, input int half_ns);
    for (int i = 0; i < ncyc; i++) begin
      ctr_in = ((($time + 64'd50) / half_ns) % 2) != 0;
      cyc();
    end
  endtask

  task automatic run_rnd(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(0, 3) == 0) ctr_in = ~ctr_in;
      cyc();
    end
  endtask

  initial begin
    logic [31:0] frozen;
    m_reset();
    #20;
    chk32("rst_tmr", tmr, 32'd0);
    chk32("rst_cp_count", cp_count, 32'd0);
    chk1("rst_to", to_flag, 1'b0);
    chk1("rst_match", match_flag, 1'b0);
    chk1("rst_cpf", cp_flag, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // One-shot down count from 20 at clk/2.
    en = 1; clk_src = 4'd1; up = 0; one_shot = 1; period = 32'd20; ctr_match = 32'd7;
    tmr_en = 0;
    cyc();
    tmr_en = 1; to_seen = 0;
    repeat (60) cyc();
    chk32("oneshot_to_count", 32'(to_seen), 32'd1);
    chk32("oneshot_hold", tmr, 32'd20);

    // Periodic up count, period 10 at clk/2: 22 clocks between timeouts.
    tmr_en = 0; up = 1; one_shot = 0; period = 32'd10; ctr_match = 32'd10;
    cyc();
    tmr_en = 1; to_seen = 0;
    repeat (70) cyc();
    chk32("periodic_interval", 32'(to_last - to_prev), 32'd22);

    // Capture on rising, falling, then both edges of a 1878 ns square wave.
    cp_en = 1; cp_event = 2'd1; cpf_seen = 0;
    run_sq(150, 939);
    chk1("cap_rise_seen", cpf_seen > 2, 1'b1);
    chk1("cap_rise_range", (cp_count >= 32'd8) && (cp_count <= 32'd10), 1'b1);
    cp_event = 2'd2;
    run_sq(150, 939);
    cp_event = 2'd3; cpf_seen = 0;
    run_sq(150, 939);
    chk1("cap_both_seen", cpf_seen > 4, 1'b1);
    chk1("cap_both_range", (cp_count >= 32'd3) && (cp_count <= 32'd5), 1'b1);

    // Asynchronous reset in the middle of a count.
    rst_n = 1'b0;
    #5;
    chk32("async_rst_tmr", tmr, 32'd0);
    chk32("async_rst_cp_count", cp_count, 32'd0);
    chk1("async_rst_to", to_flag, 1'b0);
    chk1("async_rst_match", match_flag, 1'b0);
    chk1("async_rst_cpf", cp_flag, 1'b0);
    m_reset();
    #10;
    rst_n = 1'b1;
    cp_en = 0;

    // External-edge counting with compare match, then freeze via en=0.
    clk_src = 4'd9; up = 1; one_shot = 0; period = 32'd30; ctr_match = 32'd17;
    tmr_en = 0;
    cyc();
    tmr_en = 1; match_seen = 0;
    run_rnd(300);
    chk1("ext_match_seen", match_seen > 0, 1'b1);
    frozen = m_tmr;
    en = 0;
    run_rnd(20);
    chk32("en0_freeze", tmr, frozen);
    en = 1;

    // period = 0 times out on every tick.
    clk_src = 4'd0; period = 32'd0; tmr_en = 0;
    cyc();
    tmr_en = 1; to_seen = 0;
    repeat (10) cyc();
    chk32("period0_to_count", 32'(to_seen), 32'd10);

    // Randomized configurations.
    for (int k = 0; k < 40; k++) begin
      tmr_en = 0;
      cyc();
      en        = ($urandom_range(0, 7) != 0);
      clk_src   = 4'($urandom_range(0, 15));
      up        = 1'($urandom_range(0, 1));
      one_shot  = 1'($urandom_range(0, 1));
      period    = $urandom_range(0, 40);
      ctr_match = $urandom_range(0, 40);
      cp_en     = 1'($urandom_range(0, 1));
      cp_event  = 2'($urandom_range(0, 3));
      tmr_en    = 1;
      run_rnd(50);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
